// File: rtl/pixel_streamer_28x28_if.sv
// Row-write and pixel-stream signal bundle for pixel_streamer_28x28.
interface pixel_streamer_28x28_if #(
  parameter int unsigned IMG_WIDTH = 28,
  parameter int unsigned ROW_AW    = 5
);
  logic                 wr_en;
  logic [ROW_AW-1:0]    wr_row;
  logic [IMG_WIDTH-1:0] wr_data;
  logic                 start;
  logic                 stall;
  logic                 pixel_out;
  logic                 valid_out;
  logic                 busy;
  logic                 frame_done;
  logic                 wr_err;

  // Producer side: loads rows, kicks off frames, applies back-pressure.
  modport master (
    output wr_en, wr_row, wr_data, start, stall,
    input  pixel_out, valid_out, busy, frame_done, wr_err
  );

  // Streamer side.
  modport slave (
    input  wr_en, wr_row, wr_data, start, stall,
    output pixel_out, valid_out, busy, frame_done, wr_err
  );
endinterface

// File: rtl/pixel_streamer_28x28.sv
// Binary frame buffer that streams its contents in raster order, one pixel per unstalled cycle.
module pixel_streamer_28x28 #(
  parameter int unsigned IMG_WIDTH  = 28,
  parameter int unsigned IMG_HEIGHT = 28,
  parameter int unsigned ROW_AW     = 5
) (
  input logic                   clk,
  input logic                   reset,
  pixel_streamer_28x28_if.slave bus
);
  localparam int unsigned COL_AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(IMG_HEIGHT - 1);
  localparam logic [COL_AW-1:0] LAST_COL = COL_AW'(IMG_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

  state_e               state_q, state_d;
  logic [ROW_AW-1:0]    row_q, row_d;
  logic [COL_AW-1:0]    col_q, col_d;
  logic [IMG_WIDTH-1:0] frame_q [IMG_HEIGHT];
  logic [IMG_WIDTH-1:0] frame_d [IMG_HEIGHT];
  logic                 pixel_q, pixel_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 wr_err_q, wr_err_d;
  logic                 wr_ok;

  // Next-state: row writes (IDLE only), frame sequencing and one-cycle pulses.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    frame_d  = frame_q;
    pixel_d  = pixel_q;
    valid_d  = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    wr_err_d = 1'b0;

    // A write always wins over start in the same cycle; bad or busy writes only flag.
    wr_ok = bus.wr_en && (state_q == StIdle) && (bus.wr_row <= LAST_ROW);
    if (bus.wr_en && !wr_ok) wr_err_d = 1'b1;
    if (wr_ok) frame_d[bus.wr_row] = bus.wr_data;

    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.wr_en) begin
          row_d   = '0;
          col_d   = '0;
          busy_d  = 1'b1;
          state_d = StStream;
        end
      end
      StStream: begin
        if (!bus.stall) begin
          pixel_d = frame_q[row_q][col_q];
          valid_d = 1'b1;
          if (col_q == LAST_COL) begin
            col_d = '0;
            if (row_q == LAST_ROW) state_d = StDone;
            else                   row_d   = row_q + ROW_AW'(1);
          end else begin
            col_d = col_q + COL_AW'(1);
          end
        end
      end
      StDone: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; reset also wipes the frame buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      row_q    <= '0;
      col_q    <= '0;
      frame_q  <= '{default: '0};
      pixel_q  <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      frame_q  <= frame_d;
      pixel_q  <= pixel_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign bus.pixel_out  = pixel_q;
  assign bus.valid_out  = valid_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
  assign bus.wr_err     = wr_err_q;
endmodule

// File: tb/tb_pixel_streamer_28x28.sv
// Self-checking bench for pixel_streamer_28x28 against a frame-array reference model.
module tb_pixel_streamer_28x28;
  localparam int W    = 28;
  localparam int H    = 28;
  localparam int NPIX = W * H;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [W-1:0] mbuf [H];

  pixel_streamer_28x28_if #(.IMG_WIDTH(W), .ROW_AW(5)) bus ();

  pixel_streamer_28x28 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .ROW_AW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input int row, input logic [W-1:0] data, input string tag);
    bus.wr_en   = 1'b1;
    bus.wr_row  = 5'(row);
    bus.wr_data = data;
    step();
    bus.wr_en = 1'b0;
    check({tag, "_err"}, 32'(bus.wr_err), 32'(row >= H));
    if (row < H) mbuf[row] = data;
    step();
    check({tag, "_err_clr"}, 32'(bus.wr_err), 32'd0);
  endtask

  // Starts one frame and checks it against the model: raster content, exact length,
  // valid tracking stall, and the frame_done/busy handoff right after the last pixel.
  task automatic run_frame(input bit rand_stall, input bit spam_start, input bit inject_wr,
                           input string tag);
    logic [NPIX-1:0] exp_v;
    logic [NPIX-1:0] got_v;
    int got, vs_err, pix_err, cyc, early_done;
    bit s;
    for (int i = 0; i < NPIX; i++) exp_v[i] = mbuf[i / W][i % W];
    got_v = '0; got = 0; vs_err = 0; pix_err = 0; cyc = 0; early_done = 0;
    bus.start = 1'b1;
    bus.stall = 1'b0;
    step();
    bus.start = 1'b0;
    check({tag, "_busy_on"}, 32'(bus.busy), 32'd1);
    check({tag, "_valid_after_start"}, 32'(bus.valid_out), 32'd0);
    while (got < NPIX && cyc < 4000) begin
      s = rand_stall ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.stall = s;
      if (spam_start) bus.start = 1'($urandom_range(0, 1));
      if (inject_wr && cyc == 5) begin
        bus.wr_en   = 1'b1;
        bus.wr_row  = 5'd3;
        bus.wr_data = W'($urandom);
      end
      step();
      bus.wr_en = 1'b0;
      bus.start = 1'b0;
      cyc++;
      if (inject_wr && cyc == 6) check({tag, "_busy_wr_err"}, 32'(bus.wr_err), 32'd1);
      if (inject_wr && cyc == 7) check({tag, "_busy_wr_err_clr"}, 32'(bus.wr_err), 32'd0);
      if (bus.valid_out !== !s) vs_err++;
      if (bus.frame_done !== 1'b0) early_done++;
      if (bus.valid_out === 1'b1) begin
        if (got < NPIX) got_v[got] = bus.pixel_out;
        got++;
      end
    end
    for (int i = 0; i < NPIX; i++) if (got_v[i] !== exp_v[i]) pix_err++;
    check({tag, "_count"}, 32'(got), 32'(NPIX));
    check({tag, "_pixels_wrong"}, 32'(pix_err), 32'd0);
    check({tag, "_valid_vs_stall"}, 32'(vs_err), 32'd0);
    check({tag, "_early_done"}, 32'(early_done), 32'd0);
    bus.stall = 1'($urandom_range(0, 1));
    if (spam_start) bus.start = 1'($urandom_range(0, 1));
    step();
    bus.start = 1'b0;
    bus.stall = 1'b0;
    check({tag, "_done"}, 32'(bus.frame_done), 32'd1);
    check({tag, "_busy_off"}, 32'(bus.busy), 32'd0);
    check({tag, "_valid_off"}, 32'(bus.valid_out), 32'd0);
    step();
    check({tag, "_done_clr"}, 32'(bus.frame_done), 32'd0);
  endtask

  initial begin
    logic [W-1:0] one;
    logic [W-1:0] d;
    int got, cyc, fd, bz;
    one = W'(1);
    reset = 1'b1;
    bus.wr_en = 1'b0; bus.wr_row = '0; bus.wr_data = '0; bus.start = 1'b0; bus.stall = 1'b0;
    for (int r = 0; r < H; r++) mbuf[r] = '0;
    #12;
    check("rst_pixel", 32'(bus.pixel_out), 32'd0);
    check("rst_valid", 32'(bus.valid_out), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.frame_done), 32'd0);
    check("rst_wr_err", 32'(bus.wr_err), 32'd0);
    step();
    reset = 1'b0;
    step();

    // Diagonal frame, unstalled then randomly stalled.
    for (int r = 0; r < H; r++) do_write(r, one << r, "diag_wr");
    run_frame(1'b0, 1'b0, 1'b0, "diag");
    run_frame(1'b1, 1'b0, 1'b0, "diag_stall");

    // Rejected writes: out-of-range row while idle, row 3 while streaming.
    do_write(28, W'($urandom), "oob");
    run_frame(1'b1, 1'b0, 1'b1, "busy_wr");
    run_frame(1'b0, 1'b0, 1'b0, "replay");

    // start hammered while streaming.
    run_frame(1'b0, 1'b1, 1'b0, "start_spam");

    // start together with a write in IDLE: write only, no frame.
    d = W'($urandom);
    bus.start = 1'b1; bus.wr_en = 1'b1; bus.wr_row = 5'd5; bus.wr_data = d;
    step();
    bus.start = 1'b0; bus.wr_en = 1'b0;
    mbuf[5] = d;
    check("combo_busy", 32'(bus.busy), 32'd0);
    check("combo_wr_err", 32'(bus.wr_err), 32'd0);
    check("combo_valid", 32'(bus.valid_out), 32'd0);
    step();
    check("combo_stays_idle", 32'(bus.busy), 32'd0);
    run_frame(1'b1, 1'b0, 1'b0, "combo_replay");

    // Random frame content with random stall and start noise.
    for (int r = 0; r < H; r++) do_write(r, W'($urandom), "rand_wr");
    run_frame(1'b1, 1'b1, 1'b0, "rand");

    // All-ones frame twice back-to-back without rewrite.
    for (int r = 0; r < H; r++) do_write(r, '1, "ones_wr");
    run_frame(1'b0, 1'b0, 1'b0, "ones1");
    run_frame(1'b0, 1'b0, 1'b0, "ones2");

    // Reset in the middle of a frame, after pixel 300.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    got = 0; cyc = 0;
    while (got < 300 && cyc < 2000) begin
      step();
      cyc++;
      if (bus.valid_out === 1'b1) got++;
    end
    check("abort_reached", 32'(got), 32'd300);
    check("abort_pix_before", 32'(bus.pixel_out), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("abort_pixel", 32'(bus.pixel_out), 32'd0);
    check("abort_valid", 32'(bus.valid_out), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.frame_done), 32'd0);
    check("abort_wr_err", 32'(bus.wr_err), 32'd0);
    step();
    step();
    reset = 1'b0;
    fd = 0; bz = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.frame_done !== 1'b0) fd++;
      if (bus.busy !== 1'b0) bz++;
    end
    check("abort_no_done", 32'(fd), 32'd0);
    check("abort_idle", 32'(bz), 32'd0);
    for (int r = 0; r < H; r++) mbuf[r] = '0;
    run_frame(1'b1, 1'b0, 1'b0, "post_reset_zero");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pixel_streamer_28x28.md
PIXEL_STREAMER_28X28 -- requirements
Module: pixel_streamer_28x28

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 28, pixels per row.
REQ-002 SHALL have parameter IMG_HEIGHT, default 28, rows per frame.
REQ-003 SHALL have parameter ROW_AW, default 5, row-address width (>= clog2(IMG_HEIGHT)).
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port wr_en  input  1  row-write strobe.
REQ-007 SHALL have port wr_row  input  ROW_AW  row index being written.
REQ-008 SHALL have port wr_data  input  IMG_WIDTH  row bits; bit c = column c.
REQ-009 SHALL have port start  input  1  begin streaming the stored frame.
REQ-010 SHALL have port stall  input  1  downstream hold; no pixel emitted while high.
REQ-011 SHALL have port pixel_out  output  1  registered binary pixel.
REQ-012 SHALL have port valid_out  output  1  registered; pixel_out is valid this cycle.
REQ-013 SHALL have port busy  output  1  registered; high while in STREAM or DONE.
REQ-014 SHALL have port frame_done  output  1  registered one-cycle end-of-frame pulse.
REQ-015 SHALL have port wr_err  output  1  registered one-cycle pulse on a rejected write.

Function
REQ-016 SHALL hold an IMG_HEIGHT x IMG_WIDTH bit frame buffer plus row and column counters.
REQ-017 SHALL implement FSM states IDLE, STREAM, DONE.
REQ-018 SHALL, in IDLE with wr_en=1 and wr_row<IMG_HEIGHT, write wr_data into buffer row wr_row at that edge.
REQ-019 SHALL ignore wr_en when busy or wr_row>=IMG_HEIGHT, leave buffer unchanged, and pulse wr_err the following cycle.
REQ-020 SHALL, in IDLE on start=1 with wr_en=0, clear counters, go to STREAM, set busy=1, keep valid_out=0.
REQ-021 SHALL, in IDLE with start=1 and wr_en=1 together, perform/reject the write per REQ-018/019 and ignore start.
REQ-022 SHALL ignore start while busy.
REQ-023 SHALL, in STREAM on each edge with stall=0, register buffer[row][col] onto pixel_out, set valid_out=1, advance col; at col=IMG_WIDTH-1 wrap col to 0 and increment row.
REQ-024 SHALL, in STREAM on each edge with stall=1, set valid_out=0 and hold counters and pixel_out.
REQ-025 SHALL emit raster order, row 0 col 0 first, exactly IMG_WIDTH*IMG_HEIGHT valid cycles per frame, no duplicates or skips regardless of stall pattern.
REQ-026 SHALL, on the edge emitting pixel (IMG_HEIGHT-1, IMG_WIDTH-1), go to DONE.
REQ-027 SHALL, in DONE on the next edge, set valid_out=0, frame_done=1, busy=0, go to IDLE; stall has no effect in DONE.
REQ-028 SHALL keep frame_done and wr_err high for exactly one cycle per event; pulses are cleared at the next edge.
REQ-029 SHALL give latency: start sampled at edge N -> first valid pixel after edge N+1 when stall=0; unstalled frame has IMG_WIDTH*IMG_HEIGHT consecutive valid cycles then frame_done in the next cycle.
REQ-030 SHALL preserve buffer contents across frames so start may replay a frame without rewriting.

Reset
REQ-031 SHALL, on reset assertion at any time including mid-frame, immediately set state IDLE, counters 0, frame buffer all 0, and pixel_out, valid_out, busy, frame_done, wr_err all 0.
REQ-032 SHALL not emit frame_done for a frame aborted by reset.

Verification
REQ-033 SHALL cover: write row r = 28'h0000001<<r for r=0..27, start, stall=0 -> 784 consecutive valid_out cycles; pixel_out=1 exactly at (r,c=r); frame_done pulses next cycle; busy falls with it.
REQ-034 SHALL cover: same frame with stall pseudo-random 50% -> identical 784-pixel sequence, valid_out=0 on every stalled cycle, count exactly 784.
REQ-035 SHALL cover: wr_en with wr_row=28 in IDLE, and wr_en with wr_row=3 while busy -> wr_err one-cycle pulse each, buffer unchanged on replay.
REQ-036 SHALL cover: start asserted repeatedly during STREAM, and start with wr_en same cycle -> no restart, frame length 784; combined cycle performs write only, stays IDLE.
REQ-037 SHALL cover: reset asserted after pixel 300 -> all outputs 0 immediately, no frame_done; new start streams 784 zero pixels.
REQ-038 SHALL cover: frame of all-ones rows streamed twice back-to-back without rewrite -> both frames 784 ones, two frame_done pulses.
